conv_window_ctrl: RTL and testbench

Sequencing controller for the 8-bit pixel shift-register line buffer in the CNN datapath. Accepts a raster-order pixel stream for one frame and drives the shift register's shift enable and data input. Tracks row/column position and flags each cycle where the buffered KxK window is complete and on the stride grid, so the downstream convolution engine knows when to sample. One frame per start pulse.

---
 rtl/conv_window_ctrl_if.sv | 11 +
 rtl/conv_window_ctrl.sv | 137 +++++++++++++
 tb/tb_conv_window_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_ctrl_if.sv
// Pixel stream handshake between the upstream source and the window controller.
interface conv_window_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/conv_window_ctrl.sv
// Line-buffer sequencing controller: feeds a raster pixel stream into the KxK
// shift register and flags each accepted pixel that completes an on-grid window.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; intake closed
// S_STREAM | accepting pixels whenever in_valid and not stalled
// S_DONE   | last pixel taken; one-cycle done pulse, then back to idle
module conv_window_ctrl #(
    parameter  int DATA_W = 8,
    parameter  int IMG_W  = 8,
    parameter  int IMG_H  = 8,
    parameter  int K      = 3,
    parameter  int STRIDE = 1,
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1,
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    conv_window_ctrl_if.slave    pix,
    output logic                 sr_shift_en,
    output logic [DATA_W-1:0]    sr_data,
    output logic                 win_valid,
    output logic [ROW_W-1:0]     win_row,
    output logic [COL_W-1:0]     win_col,
    output logic                 busy,
    output logic                 done
);
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_nxt;
    logic [ROW_W-1:0] row_q, row_nxt;
    logic [SW-1:0]    scol_q, scol_nxt, srow_q, srow_nxt;
    logic             accept, in_ready_c, col_last, row_last, win_hit;

    assign pix.in_ready = in_ready_c;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state, intake handshake and status outputs.
    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        accept      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        sr_data     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_STREAM;
            end
            S_STREAM: begin
                busy       = 1'b1;
                in_ready_c = !stall;
                accept     = pix.in_valid && !stall;
                sr_data    = pix.in_data;
                if (accept && col_last && row_last) state_d = S_DONE;
            end
            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        sr_shift_en = accept;
    end

    // Raster position and per-axis stride phase; phase restarts where each axis reaches K-1.
    always_comb begin
        col_last = (col_q == COL_W'(IMG_W - 1));
        row_last = (row_q == ROW_W'(IMG_H - 1));
        col_nxt  = col_last ? '0 : col_q + 1'b1;
        row_nxt  = col_last ? (row_last ? '0 : row_q + 1'b1) : row_q;

        scol_nxt = scol_q;
        if (col_nxt == COL_W'(K - 1))
            scol_nxt = '0;
        else if (col_q >= COL_W'(K - 1))
            scol_nxt = (scol_q == SW'(STRIDE - 1)) ? '0 : scol_q + 1'b1;

        srow_nxt = srow_q;
        if (col_last) begin
            if (row_nxt == ROW_W'(K - 1))
                srow_nxt = '0;
            else if (row_q >= ROW_W'(K - 1))
                srow_nxt = (srow_q == SW'(STRIDE - 1)) ? '0 : srow_q + 1'b1;
        end

        win_hit = (col_q >= COL_W'(K - 1)) && (row_q >= ROW_W'(K - 1)) &&
                  (scol_q == '0) && (srow_q == '0);
    end

    // Position counters: cleared on frame start, advanced only by accepted pixels.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            col_q  <= '0;
            row_q  <= '0;
            scol_q <= '0;
            srow_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            col_q  <= '0;
            row_q  <= '0;
            scol_q <= '0;
            srow_q <= '0;
        end else if (accept) begin
            col_q  <= col_nxt;
            row_q  <= row_nxt;
            scol_q <= scol_nxt;
            srow_q <= srow_nxt;
        end
    end

    // Window strobe one cycle after the completing pixel; coordinates hold until the next one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
        end else begin
            win_valid <= accept && win_hit;
            if (accept && win_hit) begin
                win_row <= row_q - ROW_W'(K - 1);
                win_col <= col_q - COL_W'(K - 1);
            end
        end
    end
endmodule

// File: tb/tb_conv_window_ctrl.sv
// Bench for conv_window_ctrl: three configurations (8x8 stride 1, 8x8 stride 2,
// 3x3 with K=3) share one stimulus stream and are checked every cycle against
// a raster-arithmetic model.
module tb_conv_window_ctrl;
    logic       clock;
    logic       reset;
    logic       start;
    logic       stall;
    logic       in_valid;
    logic [7:0] in_data;

    logic [2:0]      o_ready, o_shift, o_wv, o_busy, o_done;
    logic [2:0][7:0] o_data, o_row, o_col;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W   = (g == 2) ? 3 : 8;
        localparam int S   = (g == 1) ? 2 : 1;
        localparam int RW  = $clog2(W);
        localparam int CLW = $clog2(W);

        conv_window_ctrl_if #(.DATA_W(8)) pix_if ();
        logic [RW-1:0]  win_row;
        logic [CLW-1:0] win_col;

        assign pix_if.in_valid = in_valid;
        assign pix_if.in_data  = in_data;
        assign o_ready[g]      = pix_if.in_ready;
        assign o_row[g]        = 8'(win_row);
        assign o_col[g]        = 8'(win_col);

        conv_window_ctrl #(
            .DATA_W(8), .IMG_W(W), .IMG_H(W), .K(3), .STRIDE(S)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .start      (start),
            .stall      (stall),
            .pix        (pix_if),
            .sr_shift_en(o_shift[g]),
            .sr_data    (o_data[g]),
            .win_valid  (o_wv[g]),
            .win_row    (win_row),
            .win_col    (win_col),
            .busy       (o_busy[g]),
            .done       (o_done[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // model: mode 0 idle, 1 streaming, 2 done cycle
    int m_mode[3], m_p[3], m_row[3], m_col[3], m_wcnt[3];
    bit m_win[3];
    int m_first_p0;

    int obs_q[3][$];
    int gold_q[$];
    int obs_cnt[3], done_cyc[3], last_win_cyc[3];
    int shift_cnt0, last_shift_cyc0;

    function automatic int cfg_w(input int i);
        return (i == 2) ? 3 : 8;
    endfunction

    function automatic int cfg_s(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic bit all_idle();
        return (m_mode[0] == 0) && (m_mode[1] == 0) && (m_mode[2] == 0);
    endfunction

    task automatic chk(input string nm, input int i, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d", nm, i, cyc, act, exp);
        end
    endtask

    task automatic compare_all();
        bit er, es;
        for (int i = 0; i < 3; i++) begin
            if (!reset) begin
                m_mode[i] = 0;
                m_win[i]  = 1'b0;
                m_row[i]  = 0;
                m_col[i]  = 0;
            end
            er = (m_mode[i] == 1) && !stall;
            es = er && in_valid;
            chk("in_ready",    i, int'(o_ready[i]), int'(er));
            chk("sr_shift_en", i, int'(o_shift[i]), int'(es));
            chk("win_valid",   i, int'(o_wv[i]),    int'(m_win[i]));
            chk("win_row",     i, int'(o_row[i]),   m_row[i]);
            chk("win_col",     i, int'(o_col[i]),   m_col[i]);
            chk("busy",        i, int'(o_busy[i]),  int'(m_mode[i] != 0));
            chk("done",        i, int'(o_done[i]),  int'(m_mode[i] == 2));
            if (es)      chk("sr_data", i, int'(o_data[i]), int'(in_data));
            if (!reset)  chk("sr_data_rst", i, int'(o_data[i]), 0);
            if (o_wv[i]) begin
                obs_cnt[i]++;
                last_win_cyc[i] = cyc;
                obs_q[i].push_back(int'(o_row[i]) * 16 + int'(o_col[i]));
            end
            if (o_done[i]) done_cyc[i] = cyc;
        end
        if (o_shift[0]) begin
            shift_cnt0++;
            last_shift_cyc0 = cyc;
        end
    endtask

    task automatic update_model();
        int r, c, w, s;
        bit acc;
        if (!reset) return;
        for (int i = 0; i < 3; i++) begin
            w   = cfg_w(i);
            s   = cfg_s(i);
            acc = (m_mode[i] == 1) && !stall && in_valid;
            m_win[i] = 1'b0;
            case (m_mode[i])
                0: if (start) begin
                    m_mode[i] = 1;
                    m_p[i]    = 0;
                end
                1: if (acc) begin
                    r = m_p[i] / w;
                    c = m_p[i] % w;
                    if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0) begin
                        m_win[i] = 1'b1;
                        m_row[i] = r - 2;
                        m_col[i] = c - 2;
                        m_wcnt[i]++;
                        if (i == 0 && m_first_p0 < 0) m_first_p0 = m_p[i];
                    end
                    m_p[i]++;
                    if (m_p[i] == w * w) m_mode[i] = 2;
                end
                default: m_mode[i] = 0;
            endcase
        end
    endtask

    task automatic step();
        @(negedge clock);
        compare_all();
        @(posedge clock);
        update_model();
        cyc++;
        #1;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) begin
            obs_q[i].delete();
            obs_cnt[i]      = 0;
            done_cyc[i]     = -1;
            last_win_cyc[i] = -1;
            m_wcnt[i]       = 0;
        end
        shift_cnt0      = 0;
        last_shift_cyc0 = -1;
        m_first_p0      = -1;
    endtask

    task automatic run_frame(input bit gaps, input bit start_valid, input bit abort);
        int stall_left;
        clear_stats();
        start    = 1'b1;
        in_valid = start_valid;
        in_data  = 8'hAA;
        stall    = 1'b0;
        step();
        stall_left = 0;
        for (int n = 0; n < 1000; n++) begin
            if (all_idle()) break;
            if (abort && m_p[0] == 30) begin
                start    = 1'b0;
                in_valid = 1'b0;
                stall    = 1'b0;
                reset    = 1'b0;
                step();
                step();
                reset = 1'b1;
                step();
                break;
            end
            start    = 1'b0;
            stall    = 1'b0;
            in_valid = 1'b1;
            if (gaps) begin
                if (stall_left == 0 && $urandom_range(0, 5) == 0)
                    stall_left = $urandom_range(1, 5);
                stall = (stall_left > 0);
                if (stall_left > 0) stall_left--;
                in_valid = 1'($urandom_range(0, 1));
                if (m_mode[0] == 1 && m_mode[1] == 1 && m_mode[2] == 1 &&
                    $urandom_range(0, 9) == 0)
                    start = 1'b1;
            end
            in_data = 8'(m_p[0]);
            step();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        stall    = 1'b0;
        chk("frame_timeout", 0, int'(all_idle()), 1);
    endtask

    task automatic check_full_frame(input string tag);
        chk({tag, "_wins"},      0, obs_cnt[0], 36);
        chk({tag, "_model_wins"}, 0, m_wcnt[0], 36);
        chk({tag, "_shifts"},    0, shift_cnt0, 64);
        chk({tag, "_done_lat"},  0, done_cyc[0], last_shift_cyc0 + 1);
        for (int j = 0; j < 36; j++)
            chk({tag, "_order"}, 0, (j < obs_q[0].size()) ? obs_q[0][j] : -1, gold_q[j]);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        stall    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_p[i] = 0; m_row[i] = 0; m_col[i] = 0; m_win[i] = 1'b0;
        end
        clear_stats();
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();

        // Frame A: continuous stream
        run_frame(1'b0, 1'b0, 1'b0);
        chk("A_first_px",   0, m_first_p0, 18);
        chk("A_wins",       0, obs_cnt[0], 36);
        chk("A_model_wins", 0, m_wcnt[0], 36);
        chk("A_first_win",  0, (obs_q[0].size() > 0) ? obs_q[0][0] : -1, 0);
        chk("A_last_win",   0, (obs_q[0].size() >= 36) ? obs_q[0][35] : -1, 5 * 16 + 5);
        chk("A_shifts",     0, shift_cnt0, 64);
        chk("A_done_lat",   0, done_cyc[0], last_shift_cyc0 + 1);
        chk("A_s2_wins",    1, obs_cnt[1], 9);
        chk("A_s2_model",   1, m_wcnt[1], 9);
        for (int j = 0; j < 9; j++)
            chk("A_s2_coord", 1, (j < obs_q[1].size()) ? obs_q[1][j] : -1,
                (2 * (j / 3)) * 16 + 2 * (j % 3));
        chk("A_k3_wins",    2, obs_cnt[2], 1);
        chk("A_k3_coord",   2, (obs_q[2].size() > 0) ? obs_q[2][0] : -1, 0);
        chk("A_k3_coinc",   2, last_win_cyc[2], done_cyc[2]);
        gold_q = obs_q[0];
        repeat (4) step();

        // Frame B: valid gaps, stall bursts, stray start pulses
        run_frame(1'b1, 1'b0, 1'b0);
        check_full_frame("B");
        chk("B_s2_wins", 1, obs_cnt[1], 9);
        chk("B_k3_wins", 2, obs_cnt[2], 1);
        repeat (3) step();

        // Frame C: start with in_valid in idle, then reset after 30 pixels
        run_frame(1'b0, 1'b1, 1'b1);
        chk("C_partial_shifts", 0, shift_cnt0, 30);
        repeat (2) step();

        // Frame D: clean frame after mid-frame reset
        run_frame(1'b0, 1'b0, 1'b0);
        check_full_frame("D");
        chk("D_k3_wins", 2, obs_cnt[2], 1);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
